// File: rtl/regfile_scoreboard.sv
// 2**ADDR_W x DATA_W register file with write-through bypass and a per-register
// busy scoreboard that raises stall while an operand's producer is still in flight.
module regfile_scoreboard #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              busy_set,
    input  logic [ADDR_W-1:0] busy_addr,
    output logic              stall
);

    localparam int unsigned NREGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [NREGS-1:0]  busy_q;
    logic [NREGS-1:0]  busy_d;

    logic wr_valid;
    logic set_valid;
    logic hazard_rs;
    logic hazard_rt;

    assign wr_valid  = wr_en && (wr_addr != '0);
    assign set_valid = busy_set && (busy_addr != '0);

    // Clear first, then set, so a newly issued producer keeps the register pending.
    always_comb begin
        busy_d = busy_q;
        if (wr_valid) begin
            busy_d[wr_addr] = 1'b0;
        end
        if (set_valid) begin
            busy_d[busy_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            if (wr_valid) begin
                regs_q[wr_addr] <= wr_data;
            end
            busy_q <= busy_d;
        end
    end

    always_comb begin
        rs_data = regs_q[rs_addr];
        if (rs_addr == '0) begin
            rs_data = '0;
        end else if (wr_en && (wr_addr == rs_addr)) begin
            rs_data = wr_data;
        end
    end

    always_comb begin
        rt_data = regs_q[rt_addr];
        if (rt_addr == '0) begin
            rt_data = '0;
        end else if (wr_en && (wr_addr == rt_addr)) begin
            rt_data = wr_data;
        end
    end

    // busy_q[0] can never be set, so index 0 never hazards.
    assign hazard_rs = busy_q[rs_addr] && !(wr_en && (wr_addr == rs_addr));
    assign hazard_rt = busy_q[rt_addr] && !(wr_en && (wr_addr == rt_addr));
    assign stall     = hazard_rs || hazard_rt;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: directed scenarios plus randomized
// traffic compared against an array-based reference model.
module tb_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rs_addr, rt_addr, wr_addr, busy_addr;
    logic [31:0] rs_data, rt_data, wr_data;
    logic        wr_en, busy_set, stall;

    int checks = 0;
    int errors = 0;

    logic [31:0] mreg  [32];
    logic        mbusy [32];

    always #5 clk = ~clk;

    regfile_scoreboard #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .rs_addr   (rs_addr),
        .rt_addr   (rt_addr),
        .rs_data   (rs_data),
        .rt_data   (rt_data),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy_set  (busy_set),
        .busy_addr (busy_addr),
        .stall     (stall)
    );

    function automatic logic [31:0] exp_read(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (wr_en && wr_addr == a) return wr_data;
        return mreg[a];
    endfunction

    function automatic logic exp_stall();
        logic hz_rs, hz_rt;
        hz_rs = mbusy[rs_addr] && !(wr_en && wr_addr == rs_addr);
        hz_rt = mbusy[rt_addr] && !(wr_en && wr_addr == rt_addr);
        return hz_rs || hz_rt;
    endfunction

    // One clock: model follows the edge, inputs are driven on the falling edge.
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                mreg[i]  = 32'h0;
                mbusy[i] = 1'b0;
            end
        end else begin
            if (wr_en && wr_addr != 5'd0) begin
                mreg[wr_addr]  = wr_data;
                mbusy[wr_addr] = 1'b0;
            end
            if (busy_set && busy_addr != 5'd0) mbusy[busy_addr] = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        reset    = 1'b0;
        wr_en    = 1'b0;
        busy_set = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'hFFFF_FFFF;
        busy_set = 1'b1; busy_addr = 5'd4;
        tick();
        idle();
        for (int i = 0; i < 32; i++) begin
            rs_addr = 5'(i);
            rt_addr = 5'(31 - i);
            #1;
            checks++;
            if (rs_data !== 32'h0 || rt_data !== 32'h0 || stall !== 1'b0) begin
                errors++;
                $display("FAIL reset_read idx=%0d: rs=%h rt=%h stall=%b, want 0 0 0",
                         i, rs_data, rt_data, stall);
            end
        end
    endtask

    task automatic test_write_read();
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEAD_BEEF;
        tick();
        idle();
        rs_addr = 5'd5; rt_addr = 5'd5;
        #1;
        checks++;
        if (rs_data !== 32'hDEAD_BEEF || rt_data !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL write_r5: rs=%h rt=%h, want deadbeef", rs_data, rt_data);
        end
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234_5678;
        rs_addr = 5'd0; rt_addr = 5'd0;
        #1;
        checks++;
        if (rs_data !== 32'h0 || rt_data !== 32'h0) begin
            errors++;
            $display("FAIL r0_no_bypass: rs=%h rt=%h, want 0", rs_data, rt_data);
        end
        tick();
        idle();
        #1;
        checks++;
        if (rs_data !== 32'h0) begin
            errors++;
            $display("FAIL r0_write_dropped: rs=%h, want 0", rs_data);
        end
    endtask

    task automatic test_bypass();
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h1111_1111;
        tick();
        wr_data = 32'hCAFE_F00D;
        rs_addr = 5'd7; rt_addr = 5'd7;
        #1;
        checks++;
        if (rs_data !== 32'hCAFE_F00D || rt_data !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL bypass_same_cycle: rs=%h rt=%h, want cafef00d", rs_data, rt_data);
        end
        tick();
        idle();
        #1;
        checks++;
        if (rs_data !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL bypass_stored: rs=%h, want cafef00d", rs_data);
        end
    endtask

    task automatic test_stall();
        busy_set = 1'b1; busy_addr = 5'd9;
        tick();
        idle();
        rs_addr = 5'd9; rt_addr = 5'd0;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (stall !== 1'b1) begin
                errors++;
                $display("FAIL stall_pending cyc=%0d: stall=%b, want 1", c, stall);
            end
            tick();
        end
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h0000_0042;
        #1;
        checks++;
        if (stall !== 1'b0 || rs_data !== 32'h42) begin
            errors++;
            $display("FAIL stall_writeback: stall=%b rs=%h, want 0 00000042", stall, rs_data);
        end
        tick();
        idle();
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL stall_after_wb: stall=%b, want 0", stall);
        end
    endtask

    task automatic test_set_wins();
        busy_set = 1'b1; busy_addr = 5'd3;
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hA5A5_A5A5;
        tick();
        idle();
        rs_addr = 5'd0; rt_addr = 5'd3;
        #1;
        checks++;
        if (stall !== 1'b1 || rt_data !== 32'hA5A5_A5A5) begin
            errors++;
            $display("FAIL set_wins: stall=%b rt=%h, want 1 a5a5a5a5", stall, rt_data);
        end
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h0;
        tick();
        idle();
    endtask

    task automatic test_reset_mid();
        busy_set = 1'b1; busy_addr = 5'd12;
        tick();
        idle();
        rs_addr = 5'd0; rt_addr = 5'd12;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_stall: stall=%b, want 1", stall);
        end
        reset = 1'b1;
        tick();
        idle();
        #1;
        checks++;
        if (stall !== 1'b0 || rt_data !== 32'h0) begin
            errors++;
            $display("FAIL post_reset: stall=%b rt=%h, want 0 0", stall, rt_data);
        end
        busy_set = 1'b1; busy_addr = 5'd0;
        tick();
        idle();
        rs_addr = 5'd0; rt_addr = 5'd0;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL busy_r0: stall=%b, want 0", stall);
        end
        wr_en = 1'b1; wr_addr = 5'd12; wr_data = 32'h0BAD_CAFE;
        tick();
        idle();
        rt_addr = 5'd12;
        #1;
        checks++;
        if (stall !== 1'b0 || rt_data !== 32'h0BAD_CAFE) begin
            errors++;
            $display("FAIL post_reset_write: stall=%b rt=%h, want 0 0badcafe", stall, rt_data);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            reset     = ($urandom_range(0, 40) == 0);
            wr_en     = $urandom_range(0, 1) == 1;
            busy_set  = $urandom_range(0, 2) == 0;
            // Narrow address range so hazards, bypasses and collisions are frequent.
            wr_addr   = 5'($urandom_range(0, 7));
            busy_addr = 5'($urandom_range(0, 7));
            rs_addr   = 5'($urandom_range(0, 7));
            rt_addr   = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31))
                                                    : 5'($urandom_range(0, 7));
            wr_data   = $urandom;
            #1;
            checks++;
            if (rs_data !== exp_read(rs_addr) || rt_data !== exp_read(rt_addr)
                || stall !== exp_stall()) begin
                errors++;
                $display("FAIL random n=%0d rs%0d=%h rt%0d=%h stall=%b, want %h %h %b",
                         n, rs_addr, rs_data, rt_addr, rt_data, stall,
                         exp_read(rs_addr), exp_read(rt_addr), exp_stall());
            end
            tick();
        end
        idle();
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; busy_set = 1'b0;
        rs_addr = '0; rt_addr = '0; wr_addr = '0; busy_addr = '0; wr_data = '0;
        for (int i = 0; i < 32; i++) begin
            mreg[i]  = 32'h0;
            mbusy[i] = 1'b0;
        end
        @(negedge clk);
        test_reset();
        test_write_read();
        test_bypass();
        test_stall();
        test_set_wins();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
